// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer: drains BURST_LENGTH words from the FIFO and checks them against an incrementing pattern.
// Optional empty-stall watchdog is enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader #(
    parameter int DATASIZE       = 8,
    parameter int ADDRSIZE       = 10,
    parameter int READ_PERIOD    = 1,
    parameter int BURST_LENGTH   = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  rclk,
    input  logic                                  rrst,
    input  logic                                  start,
    input  logic [DATASIZE-1:0]                   seed,
    input  logic [DATASIZE-1:0]                   rdata,
    input  logic                                  rempty,
    output logic                                  rinc,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(BURST_LENGTH+1)-1:0]     word_count,
    output logic [15:0]                           err_count,
    output logic [$clog2(BURST_LENGTH+1)-1:0]     first_err_idx,
    output logic [DATASIZE-1:0]                   first_err_data,
    output logic                                  err_valid,
    output logic                                  timeout
);

    localparam int CW = $clog2(BURST_LENGTH + 1);
    localparam int GW = $clog2(READ_PERIOD + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         wc_q, wc_d;
    logic [15:0]           err_q, err_d;
    logic [CW-1:0]         fidx_q, fidx_d;
    logic [DATASIZE-1:0]   fdata_q, fdata_d;
    logic                  ev_q, ev_d;
    logic [DATASIZE-1:0]   exp_q, exp_d;
    logic [GW-1:0]         gap_q, gap_d;
`ifdef FIFO_RD_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0]         stall_q, stall_d;
    logic                  timeout_q, timeout_d;
`endif

    // Head data is presented combinationally, so a pop and its data check share one cycle.
    assign rinc = (state_q == S_READ) && !rempty;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        wc_d    = wc_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fdata_d = fdata_q;
        ev_d    = ev_q;
        exp_d   = exp_q;
        gap_d   = gap_q;
`ifdef FIFO_RD_TIMEOUT_EN
        stall_d   = stall_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    wc_d    = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fdata_d = '0;
                    ev_d    = 1'b0;
                    exp_d   = seed;
                    gap_d   = '0;
`ifdef FIFO_RD_TIMEOUT_EN
                    stall_d   = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            S_READ: begin
                if (!rempty) begin
                    wc_d  = wc_q + 1'b1;
                    exp_d = exp_q + 1'b1;
                    if (rdata != exp_q) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
                        if (!ev_q) begin
                            ev_d    = 1'b1;
                            fidx_d  = wc_q;
                            fdata_d = rdata;
                        end
                    end
                    if (wc_q == CW'(BURST_LENGTH - 1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (READ_PERIOD > 1) begin
                        state_d = S_GAP;
                        gap_d   = GW'(READ_PERIOD - 1);
                    end
`ifdef FIFO_RD_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
`ifdef FIFO_RD_TIMEOUT_EN
                else begin
                    stall_d = stall_q + 1'b1;
                    if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
`endif
            end
            S_GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GW'(1)) state_d = S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wc_q    <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fdata_q <= '0;
            ev_q    <= 1'b0;
            exp_q   <= '0;
            gap_q   <= '0;
`ifdef FIFO_RD_TIMEOUT_EN
            stall_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fdata_q <= fdata_d;
            ev_q    <= ev_d;
            exp_q   <= exp_d;
            gap_q   <= gap_d;
`ifdef FIFO_RD_TIMEOUT_EN
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign word_count     = wc_q;
    assign err_count      = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_data = fdata_q;
    assign err_valid      = ev_q;
`ifdef FIFO_RD_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model feeding two instances (READ_PERIOD 1 and 3).
// Expected results are derived from the list of words actually popped and the burst seed.
module tb_fifo_burst_reader;

    localparam int BL = 1024;
    localparam int CW = 11;
    localparam int TO = 16;

    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic          rrst, start_a, start_b, rempty;
    logic [7:0]    seed_in, rdata;
    logic          rinc_a, busy_a, done_a, ev_a, to_a;
    logic          rinc_b, busy_b, done_b, ev_b, to_b;
    logic [CW-1:0] wc_a, fidx_a, wc_b, fidx_b;
    logic [15:0]   ec_a, ec_b;
    logic [7:0]    fd_a, fd_b;

    fifo_burst_reader #(.DATASIZE(8), .ADDRSIZE(10), .READ_PERIOD(1), .BURST_LENGTH(BL),
                        .TIMEOUT_CYCLES(TO)) dut_a (
        .rclk(rclk), .rrst(rrst), .start(start_a), .seed(seed_in), .rdata(rdata), .rempty(rempty),
        .rinc(rinc_a), .busy(busy_a), .done(done_a), .word_count(wc_a), .err_count(ec_a),
        .first_err_idx(fidx_a), .first_err_data(fd_a), .err_valid(ev_a), .timeout(to_a));

    fifo_burst_reader #(.DATASIZE(8), .ADDRSIZE(10), .READ_PERIOD(3), .BURST_LENGTH(BL),
                        .TIMEOUT_CYCLES(TO)) dut_b (
        .rclk(rclk), .rrst(rrst), .start(start_b), .seed(seed_in), .rdata(rdata), .rempty(rempty),
        .rinc(rinc_b), .busy(busy_b), .done(done_b), .word_count(wc_b), .err_count(ec_b),
        .first_err_idx(fidx_b), .first_err_data(fd_b), .err_valid(ev_b), .timeout(to_b));

    logic          sel_b = 1'b0;
    logic          o_rinc, o_busy, o_done, o_ev, o_to;
    logic [CW-1:0] o_wc, o_fidx;
    logic [15:0]   o_ec;
    logic [7:0]    o_fd;
    assign o_rinc = sel_b ? rinc_b : rinc_a;
    assign o_busy = sel_b ? busy_b : busy_a;
    assign o_done = sel_b ? done_b : done_a;
    assign o_ev   = sel_b ? ev_b   : ev_a;
    assign o_to   = sel_b ? to_b   : to_a;
    assign o_wc   = sel_b ? wc_b   : wc_a;
    assign o_fidx = sel_b ? fidx_b : fidx_a;
    assign o_ec   = sel_b ? ec_b   : ec_a;
    assign o_fd   = sel_b ? fd_b   : fd_a;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         rinc_viol = 0;
    logic [7:0] fifo[$];
    logic [7:0] popped[$];
    int         rd_cycles[$];
    bit         hold_empty = 1'b0;
    bit         rand_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        rempty = hold_empty || (fifo.size() == 0);
        rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: sample rinc before the edge, pop after it.
    task automatic step();
        bit rd;
        #1;
        rd = rinc_a | rinc_b;
        if (rd && rempty) begin
            rinc_viol++;
            rd = 1'b0;
        end
        if (rd) begin
            popped.push_back(fifo[0]);
            rd_cycles.push_back(cyc);
        end
        @(posedge rclk);
        #1;
        cyc++;
        if (rd) void'(fifo.pop_front());
        if (rand_stall) hold_empty = ($urandom_range(0, 5) == 0);
        refresh();
    endtask

    task automatic fill(input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) fifo.push_back(s + 8'(i));
    endtask

    task automatic check_reset(input string tag);
        #1;
        chk({tag, "_rinc"}, o_rinc, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_wc"}, o_wc, 0);
        chk({tag, "_ec"}, o_ec, 0);
        chk({tag, "_fidx"}, o_fidx, 0);
        chk({tag, "_fdata"}, o_fd, 0);
        chk({tag, "_ev"}, o_ev, 0);
        chk({tag, "_to"}, o_to, 0);
    endtask

    task automatic do_start(input bit b, input logic [7:0] s);
        sel_b   = b;
        seed_in = s;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        popped.delete();
        rd_cycles.delete();
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        chk("start_busy", o_busy, 1);
        chk("start_done", o_done, 0);
        chk("start_wc", o_wc, 0);
    endtask

    task automatic run_done(input int budget);
        int k = 0;
        while (!o_done && k < budget) begin
            step();
            k++;
        end
        chk("done_reached", o_done, 1);
    endtask

    task automatic run_pops(input int n, input int budget);
        int k = 0;
        while (popped.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("pops_reached", popped.size(), n);
    endtask

    // Reference: compare every popped word with seed+index, modulo 256.
    task automatic check_model(input string tag, input logic [7:0] s, input int exp_n,
                               input bit exp_done, input bit exp_to);
        int ec = 0;
        int fidx = 0;
        int fdat = 0;
        bit ev = 1'b0;
        for (int i = 0; i < popped.size(); i++) begin
            if (popped[i] != 8'((int'(s) + i) % 256)) begin
                ec++;
                if (!ev) begin
                    ev   = 1'b1;
                    fidx = i;
                    fdat = popped[i];
                end
            end
        end
        chk({tag, "_npop"}, popped.size(), exp_n);
        chk({tag, "_wc"}, o_wc, popped.size());
        chk({tag, "_ec"}, o_ec, ec);
        chk({tag, "_ev"}, o_ev, ev);
        chk({tag, "_fidx"}, o_fidx, fidx);
        chk({tag, "_fdata"}, o_fd, fdat);
        chk({tag, "_done"}, o_done, exp_done);
        chk({tag, "_busy"}, o_busy, !exp_done);
        chk({tag, "_to"}, o_to, exp_to);
        chk({tag, "_rinc_empty"}, rinc_viol, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int bad;
        logic [7:0] s, v;
        rrst = 1'b1; start_a = 1'b0; start_b = 1'b0; seed_in = 8'h00;
        refresh();
        repeat (3) step();
        rrst = 1'b0;
        check_reset("rst_a");
        sel_b = 1'b1;
        check_reset("rst_b");

        // Back-to-back burst at READ_PERIOD=1
        fill(8'h00, BL);
        do_start(1'b0, 8'h00);
        run_done(BL + 50);
        check_model("t1", 8'h00, BL, 1'b1, 1'b0);
        chk("t1_span", rd_cycles[rd_cycles.size()-1] - rd_cycles[0], BL - 1);

        // READ_PERIOD=3 with pattern wrap
        fill(8'h10, BL);
        do_start(1'b1, 8'h10);
        run_done(3 * BL + 50);
        check_model("t2", 8'h10, BL, 1'b1, 1'b0);
        bad = 0;
        for (int i = 1; i < rd_cycles.size(); i++)
            if (rd_cycles[i] - rd_cycles[i-1] != 3) bad++;
        chk("t2_spacing", bad, 0);
        chk("t2_span", rd_cycles[rd_cycles.size()-1] - rd_cycles[0], 3 * (BL - 1));

        // Two corrupted words, restart from DONE
        fill(8'h00, BL);
        fifo[5] = 8'hA5;
        fifo[9] = 8'h3C;
        do_start(1'b0, 8'h00);
        run_done(BL + 50);
        check_model("t3", 8'h00, BL, 1'b1, 1'b0);
        chk("t3_ec_abs", o_ec, 2);
        chk("t3_fidx_abs", o_fidx, 5);
        chk("t3_fdata_abs", o_fd, 8'hA5);

        // Empty stall after word 100, with an ignored start mid-stall
        fill(8'h00, 100);
        do_start(1'b0, 8'h00);
        run_pops(100, 200);
        for (int i = 0; i < 20; i++) begin
            start_a = (i == 5);
            seed_in = (i == 5) ? 8'h77 : 8'h00;
            step();
            if (i == 10) chk("t4_wc_mid", o_wc, 100);
        end
        start_a = 1'b0;
        chk("t4_wc_hold", o_wc, 100);
        chk("t4_busy_hold", o_busy, 1);
        chk("t4_pops_hold", popped.size(), 100);
        fill(8'd100, BL - 100);
        run_done(BL + 50);
        check_model("t4", 8'h00, BL, 1'b1, 1'b0);

        // Reset mid-burst, then a new burst from seed 0x2C
        fifo.delete();
        fill(8'h00, BL);
        do_start(1'b0, 8'h00);
        run_pops(300, 400);
        hold_empty = 1'b1;
        refresh();
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        hold_empty = 1'b0;
        fifo.delete();
        refresh();
        check_reset("t5_rst");
        chk("t5_pops", popped.size(), 300);
        fill(8'h2C, BL);
        fifo[0] = 8'hE1;
        do_start(1'b0, 8'h2C);
        run_done(BL + 50);
        check_model("t5", 8'h2C, BL, 1'b1, 1'b0);
        chk("t5_fidx_abs", o_fidx, 0);

        // Random seeds, sparse corruption, random empty stalls
        for (int r = 0; r < 4; r++) begin
            s = 8'($urandom);
            for (int i = 0; i < BL; i++) begin
                v = s + 8'(i);
                if ($urandom_range(0, 63) == 0) v = v ^ 8'($urandom_range(1, 255));
                fifo.push_back(v);
            end
            rand_stall = 1'b1;
            do_start(r[0], s);
            run_done(6 * BL);
            rand_stall = 1'b0;
            hold_empty = 1'b0;
            refresh();
            check_model($sformatf("rnd%0d", r), s, BL, 1'b1, 1'b0);
        end

        // FIFO runs dry after 50 words
        fifo.delete();
        fill(8'h40, 50);
        do_start(1'b0, 8'h40);
        run_pops(50, 100);
`ifdef FIFO_RD_TIMEOUT_EN
        repeat (TO - 1) step();
        chk("t7_to_early", o_to, 0);
        chk("t7_busy_early", o_busy, 1);
        step();
        check_model("t7", 8'h40, 50, 1'b1, 1'b1);
`else
        repeat (40) step();
        chk("t7_wc_stall", o_wc, 50);
        chk("t7_busy_stall", o_busy, 1);
        chk("t7_done_stall", o_done, 0);
        chk("t7_to_stall", o_to, 0);
        fill(8'h40 + 8'd50, BL - 50);
        run_done(BL + 50);
        check_model("t7", 8'h40, BL, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side burst consumer for the asynchronous FIFO. It sits in the read clock domain on the FIFO read port (rdata/rempty/rinc). It drains BURST_LENGTH words, spaced at most one read every READ_PERIOD cycles, and checks each word against an incrementing pattern that starts at a programmable seed. It reports completion, word count, mismatch count and the first failing word. It is the counterpart of the write-side burst generator/driver.

Parameters:
DATASIZE, 8, FIFO data width
ADDRSIZE, 10, FIFO address width; informational only, not used for logic
READ_PERIOD, 1, minimum cycles between successive reads; must be >= 1
BURST_LENGTH, 1024, words per burst; must be >= 1
TIMEOUT_CYCLES, 4096, empty-stall limit; used only with FIFO_RD_TIMEOUT_EN

Ports:
rclk  input  1  read-domain clock
rrst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse to begin a burst; ignored unless state is IDLE or DONE
seed  input  DATASIZE  expected value of word 0; sampled on an accepted start
rdata  input  DATASIZE  FIFO read data; valid whenever rempty=0
rempty  input  1  FIFO empty flag
rinc  output  1  FIFO read increment
busy  output  1  burst in progress
done  output  1  burst complete; held until next accepted start or reset
word_count  output  $clog2(BURST_LENGTH+1)  words read in current/last burst
err_count  output  16  mismatch count; saturates at 16'hFFFF
first_err_idx  output  $clog2(BURST_LENGTH+1)  index of first mismatching word
first_err_data  output  DATASIZE  rdata captured at first mismatch
err_valid  output  1  at least one mismatch in current/last burst
timeout  output  1  burst aborted by watchdog; tied 0 without FIFO_RD_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock, rclk. Reset is synchronous, active-high on rrst and is sampled on the rclk rising edge.
- Reset values: rinc=0, busy=0, done=0, word_count=0, err_count=0, first_err_idx=0, first_err_data=0, err_valid=0, timeout=0. State goes to IDLE, expected value to 0, gap counter to 0.
- States: IDLE, READ, GAP, DONE.
- IDLE/DONE + start:
  - Clear done, word_count, err_count, err_valid, timeout, first_err_*.
  - Load expected <= seed, then go to READ. busy=1 from the next cycle.
- READ:
  - rinc = 1 exactly when state==READ and rempty==0. This is combinational from registered state and the rempty input. rinc must never be 1 while rempty==1.
  - On a cycle with rinc=1, sample rdata in the same cycle. The FIFO presents head data combinationally, so latency is 0.
  - On that cycle: word_count++ and expected <= expected+1 (mod 2^DATASIZE; wraps 255->0 for DATASIZE=8).
  - If rdata != expected: err_count++ (saturating). If err_valid==0, also capture first_err_idx=word_count (pre-increment) and first_err_data=rdata, and set err_valid=1.
  - Next state after a read:
    - word_count+1 == BURST_LENGTH: go to DONE.
    - else READ_PERIOD>1: go to GAP with gap counter = READ_PERIOD-1.
    - else stay in READ.
  - rempty==1: stay in READ with no read and no counter change.
- GAP: rinc=0. Decrement the gap counter; go to READ when it reaches 1. This gives exactly READ_PERIOD cycles between rinc pulses when the FIFO is not empty.
- DONE: busy=0, done=1. Counters hold. A start restarts from seed in the same manner as from IDLE.
- start while busy: ignored, with no effect on counters.
- rrst mid-burst: abort immediately to reset values. The FIFO is not touched further, and words already popped are not replayed.
- rempty glitch-free: synchronisation is the FIFO's responsibility; this block consumes rempty as-is.

Optional Feature:
FIFO_RD_TIMEOUT_EN
- Defined:
  - A stall counter increments on each READ cycle with rempty==1 and clears on any read or on an accepted start.
  - When it reaches TIMEOUT_CYCLES, set timeout=1 and go to DONE with done=1. word_count holds the partial count.
- Undefined: no stall counter, timeout tied 0, and the block waits in READ indefinitely.

Test Plan:
- Reset, then start with seed=0x00; FIFO preloaded 0,1,...,255,0,... (1024 words), READ_PERIOD=1 -> 1024 consecutive rinc cycles, done=1, word_count=1024, err_count=0, err_valid=0.
- READ_PERIOD=3, seed=0x10, FIFO full -> rinc pulses exactly 3 cycles apart, done after 3*1023+1 cycles of READ/GAP, expected wraps 0xFF->0x00 with no errors.
- Corrupt word index 5 (0x05 -> 0xA5) and index 9, seed=0 -> err_count=2, err_valid=1, first_err_idx=5, first_err_data=0xA5.
- FIFO empty for 20 cycles mid-burst after word 100 -> rinc=0 throughout the stall, word_count holds 100, burst resumes and completes at 1024.
- Assert rrst at word 300, then start with seed=0x2C -> all outputs reset to 0, new burst expects 0x2C first, and the old counts are not retained.
- With FIFO_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16: FIFO empties after 50 words -> timeout=1, done=1, word_count=50 on the 16th empty cycle. Without the macro, the block stays busy.
